// File: rtl/cosinehw_pkg.sv
// Shared constants, register map and FSM encoding for the cosine
// similarity accelerator control block.
package cosinehw_pkg;

    localparam int unsigned ElemWidth = 8;
    localparam int unsigned NumElems  = 4;
    localparam int unsigned AccWidth  = 32;

    localparam logic [7:0] RegCtrl   = 8'h00;
    localparam logic [7:0] RegStatus = 8'h04;
    localparam logic [7:0] RegAvec   = 8'h08;
    localparam logic [7:0] RegBvec   = 8'h0C;
    localparam logic [7:0] RegCos    = 8'h10;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ACCUM = 3'd1,
        S_CHECK = 3'd2,
        S_REQ   = 3'd3,
        S_WAIT  = 3'd4,
        S_DONE  = 3'd5
    } state_e;

endpackage

// File: rtl/cosinehw_mac.sv
// Three signed multiply-accumulate paths: sum(a*b), sum(a*a), sum(b*b).
// Cleared on start, advanced one element per enabled cycle.
module cosinehw_mac #(
    parameter int unsigned ElemWidth = 8,
    parameter int unsigned AccWidth  = 32
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        clr_i,
    input  logic                        en_i,
    input  logic signed [ElemWidth-1:0] a_i,
    input  logic signed [ElemWidth-1:0] b_i,
    output logic        [AccWidth-1:0]  dot_o,
    output logic        [AccWidth-1:0]  aa_o,
    output logic        [AccWidth-1:0]  bb_o
);

    localparam int unsigned PW = 2 * ElemWidth;

    logic signed [PW-1:0] p_ab, p_aa, p_bb;
    logic [AccWidth-1:0] dot_q, aa_q, bb_q;
    logic [AccWidth-1:0] dot_d, aa_d, bb_d;

    function automatic logic [AccWidth-1:0] sext(input logic [PW-1:0] p);
        return {{(AccWidth - PW){p[PW-1]}}, p};
    endfunction

    assign p_ab = a_i * b_i;
    assign p_aa = a_i * a_i;
    assign p_bb = b_i * b_i;

    always_comb begin
        dot_d = dot_q;
        aa_d  = aa_q;
        bb_d  = bb_q;
        if (clr_i) begin
            dot_d = '0;
            aa_d  = '0;
            bb_d  = '0;
        end else if (en_i) begin
            dot_d = dot_q + sext(p_ab);
            aa_d  = aa_q + sext(p_aa);
            bb_d  = bb_q + sext(p_bb);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dot_q <= '0;
            aa_q  <= '0;
            bb_q  <= '0;
        end else begin
            dot_q <= dot_d;
            aa_q  <= aa_d;
            bb_q  <= bb_d;
        end
    end

    assign dot_o = dot_q;
    assign aa_o  = aa_q;
    assign bb_o  = bb_q;

endmodule

// File: rtl/cosinehw_ctrl.sv
// Sequencer for cosine similarity: accumulates dot/norms element by element,
// hands them to an external normalizer and holds the returned result.
module cosinehw_ctrl #(
    parameter int unsigned ElemWidth = cosinehw_pkg::ElemWidth,
    parameter int unsigned NumElems  = cosinehw_pkg::NumElems,
    parameter int unsigned AccWidth  = cosinehw_pkg::AccWidth
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          start_i,
    input  logic                          clear_i,
    input  logic [NumElems*ElemWidth-1:0] avec_i,
    input  logic [NumElems*ElemWidth-1:0] bvec_i,
    output logic                          busy_o,
    output logic                          done_o,
    output logic [31:0]                   cos_o,
    output logic                          norm_req_valid_o,
    input  logic                          norm_req_ready_i,
    output logic [AccWidth-1:0]           norm_dot_o,
    output logic [AccWidth-1:0]           norm_aa_o,
    output logic [AccWidth-1:0]           norm_bb_o,
    input  logic                          norm_rsp_valid_i,
    input  logic [31:0]                   norm_rsp_data_i
);

    import cosinehw_pkg::*;

    localparam int unsigned VecW = NumElems * ElemWidth;
    localparam int unsigned CntW = (NumElems > 1) ? $clog2(NumElems) : 1;

    state_e state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [VecW-1:0] a_q, a_d, b_q, b_d;
    logic [31:0] cos_q, cos_d;

    logic mac_clr, mac_en;
    logic signed [ElemWidth-1:0] a_el, b_el;
    logic [AccWidth-1:0] dot, aa, bb;

    always_comb begin
        a_el = '0;
        b_el = '0;
        for (int i = 0; i < int'(NumElems); i++) begin
            if (cnt_q == CntW'(i)) begin
                a_el = a_q[i*ElemWidth +: ElemWidth];
                b_el = b_q[i*ElemWidth +: ElemWidth];
            end
        end
    end

    cosinehw_mac #(
        .ElemWidth(ElemWidth),
        .AccWidth (AccWidth)
    ) u_mac (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .clr_i (mac_clr),
        .en_i  (mac_en),
        .a_i   (a_el),
        .b_i   (b_el),
        .dot_o (dot),
        .aa_o  (aa),
        .bb_o  (bb)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        cos_d   = cos_q;
        mac_clr = 1'b0;
        mac_en  = 1'b0;
        // clear overrides everything, including a simultaneous start
        if (clear_i) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_i) begin
                        state_d = S_ACCUM;
                        a_d     = avec_i;
                        b_d     = bvec_i;
                        cnt_d   = '0;
                        mac_clr = 1'b1;
                    end
                end
                S_ACCUM: begin
                    mac_en = 1'b1;
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == CntW'(NumElems - 1)) begin
                        state_d = S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (aa == '0 || bb == '0) begin
                        cos_d   = '0;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_REQ;
                    end
                end
                S_REQ: begin
                    if (norm_req_ready_i) begin
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (norm_rsp_valid_i) begin
                        cos_d   = norm_rsp_data_i;
                        state_d = S_DONE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cos_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cos_q   <= cos_d;
        end
    end

    assign busy_o           = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done_o           = (state_q == S_DONE);
    assign norm_req_valid_o = (state_q == S_REQ);
    assign cos_o            = cos_q;
    assign norm_dot_o       = dot;
    assign norm_aa_o        = aa;
    assign norm_bb_o        = bb;

endmodule

// File: doc/cosinehw_ctrl.md
COSINEHW_CTRL -- requirements
Module: cosinehw_ctrl

Interface
REQ-001 Parameters SHALL be: ElemWidth, default 8, signed element width; NumElems, default 4, elements per 32-bit vector word; AccWidth, default 32, accumulator width.
REQ-002 Clocking SHALL be one clock; reset is asynchronous and active-low.
REQ-003 clk_i  input  1  rising-edge clock.
REQ-004 rst_ni  input  1  asynchronous active-low reset.
REQ-005 start_i  input  1  single-cycle start pulse from the START register write.
REQ-006 clear_i  input  1  abort/acknowledge; clears done_o.
REQ-007 avec_i  input  32  packed vector A; element i = bits [8i+7:8i].
REQ-008 bvec_i  input  32  packed vector B, same packing.
REQ-009 busy_o  output  1  high in every state except IDLE and DONE.
REQ-010 done_o  output  1  high only in DONE.
REQ-011 cos_o  output  32  result word.
REQ-012 norm_req_valid_o  output  1  request to the external normalizer.
REQ-013 norm_req_ready_i  input  1  normalizer accepts the request.
REQ-014 norm_dot_o, norm_aa_o, norm_bb_o  output  32 each  sum(a*b), sum(a*a), sum(b*b).
REQ-015 norm_rsp_valid_i  input  1  normalizer result strobe.
REQ-016 norm_rsp_data_i  input  32  normalizer result.

Function
REQ-017 The FSM SHALL have states IDLE, ACCUM, CHECK, REQ, WAIT, DONE.
REQ-018 In IDLE or DONE, start_i SHALL snapshot avec_i/bvec_i, zero all accumulators and the element counter, and enter ACCUM; done_o falls in the same transition.
REQ-019 ACCUM SHALL process exactly one element per cycle, index 0..NumElems-1 ascending, then enter CHECK.
REQ-020 Products SHALL be signed ElemWidth x ElemWidth -> 2*ElemWidth, sign-extended to AccWidth; dot is signed; aa/bb are non-negative; no saturation is needed at default widths.
REQ-021 CHECK SHALL enter DONE with cos_o = 0 if aa == 0 or bb == 0, otherwise enter REQ.
REQ-022 In REQ, norm_req_valid_o SHALL be 1 and norm_*_o SHALL stay stable until norm_req_ready_i is 1; the handshake cycle then moves to WAIT.
REQ-023 In WAIT, norm_rsp_valid_i SHALL load cos_o from norm_rsp_data_i and enter DONE; a strobe outside WAIT SHALL be ignored.
REQ-024 DONE SHALL hold done_o = 1 and cos_o until clear_i (to IDLE) or start_i (restart).
REQ-025 start_i while busy_o = 1 SHALL be ignored, with no effect on state or data.
REQ-026 clear_i in any state SHALL return to IDLE next cycle and drop norm_req_valid_o, the only allowed valid withdrawal; cos_o is retained.
REQ-027 clear_i and start_i in the same cycle: clear_i SHALL win.
REQ-028 Latency SHALL be as follows, with start in cycle 0, ready = 1, and the response in the first WAIT cycle: ACCUM in cycles 1-4, CHECK in cycle 5, handshake in cycle 6, WAIT in cycle 7, done_o = 1 in cycle 8. A zero vector SHALL give done_o = 1 in cycle 6.

Reset
REQ-029 Reset SHALL force state = IDLE; busy_o, done_o and norm_req_valid_o = 0; cos_o, accumulators, counter and snapshots = 0.
REQ-030 Reset asserted mid-operation SHALL abandon the computation immediately, with no request or result emitted afterwards.

Structure
REQ-031 The state enum and the ElemWidth, NumElems and AccWidth constants SHALL live in cosinehw_pkg beside the existing register offsets.
REQ-032 One sub-module, cosinehw_mac, SHALL hold the three product/accumulate paths; the FSM, counter and handshake stay in cosinehw_ctrl.

Verification
REQ-033 A = B = 0x01010101, ready = 1, rsp 0x00010000 in cycle 7 -> norm_* = 4/4/4 at handshake in cycle 6, done_o in cycle 8, cos_o = 0x00010000.
REQ-034 A = 0xFF02FF02, B = 0x01010101 -> dot = 2, aa = 10, bb = 4.
REQ-035 A = B = 0x80808080 -> dot = aa = bb = 65536, with no overflow.
REQ-036 A = 0x00000000, B = 0x01010101 -> norm_req_valid_o never rises, done_o in cycle 6, cos_o = 0.
REQ-037 norm_req_ready_i held low for 5 cycles -> valid and norm_* stable throughout; start_i pulsed during this wait is ignored; then ready rises -> normal completion.
REQ-038 clear_i during WAIT -> IDLE next cycle; a later norm_rsp_valid_i is ignored; done_o stays 0; rst_ni low during ACCUM -> all outputs reset immediately.
